// File: rtl/mem_access_seq_if.sv
// Memory access sequencer bus: fetch/execute request channels plus the
// MAR/MBR/RAM control strobes and status driven back by the sequencer.
interface mem_access_seq_if #(
  parameter int ADDR_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              e_req;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;

  logic [ADDR_W-1:0] mar_out;
  logic              mar_ld;
  logic              mbr_ld_ram;
  logic              mbr_ld_acc;
  logic              ram_we;
  logic              f_ack;
  logic              e_ack;
  logic              gnt_e;
  logic              busy;

  // requester / control-unit side
  modport master (
    output f_req, f_addr, e_req, e_we, e_addr,
    input  mar_out, mar_ld, mbr_ld_ram, mbr_ld_acc, ram_we,
    input  f_ack, e_ack, gnt_e, busy
  );

  // sequencer side
  modport slave (
    input  f_req, f_addr, e_req, e_we, e_addr,
    output mar_out, mar_ld, mbr_ld_ram, mbr_ld_acc, ram_we,
    output f_ack, e_ack, gnt_e, busy
  );
endinterface

// File: rtl/mem_access_seq.sv
// Memory access sequencer: round-robin arbitration between instruction fetch
// and execute-stage accesses, with programmable RAM wait states.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch address/op on grant
// ADDR  | MAR load strobe
// RWAIT | read wait states, WAIT_STATES cycles
// RD    | MBR <- RAM strobe
// WLD   | MBR <- ACC strobe
// WR    | RAM write enable, WAIT_STATES+1 cycles
// ACK   | one-cycle acknowledge to the granted side
module mem_access_seq #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_access_seq_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_RWAIT = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WLD   = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_ACK   = 3'd6;

  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  // terminal count for read waits; unused when WS is zero since RWAIT is skipped
  localparam logic [3:0] WS_RD_TC = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic              we_q,    we_d;
  logic              gnt_e_q, gnt_e_d;
  logic [3:0]        cnt_q,   cnt_d;
  logic              grant_e;

  // next-state, arbitration and wait counting
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    we_d    = we_q;
    gnt_e_d = gnt_e_q;
    cnt_d   = cnt_q;
    grant_e = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.e_req) begin
          // with both requesting, the side that did not hold the last grant wins
          grant_e = bus.e_req && (!bus.f_req || !gnt_e_q);
          mar_d   = grant_e ? bus.e_addr : bus.f_addr;
          we_d    = grant_e && bus.e_we;
          gnt_e_d = grant_e;
          cnt_d   = 4'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (we_q)             state_d = S_WLD;
        else if (WS != 4'd0)  state_d = S_RWAIT;
        else                  state_d = S_RD;
      end
      S_RWAIT: begin
        if (cnt_q == WS_RD_TC) state_d = S_RD;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      S_RD:  state_d = S_ACK;
      S_WLD: begin
        cnt_d   = 4'd0;
        state_d = S_WR;
      end
      S_WR: begin
        if (cnt_q == WS) state_d = S_ACK;
        else             cnt_d   = cnt_q + 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset aborts any access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      we_q    <= 1'b0;
      gnt_e_q <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      we_q    <= we_d;
      gnt_e_q <= gnt_e_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mar_out    = mar_q;
  assign bus.gnt_e      = gnt_e_q;
  assign bus.mar_ld     = (state_q == S_ADDR);
  assign bus.mbr_ld_ram = (state_q == S_RD);
  assign bus.mbr_ld_acc = (state_q == S_WLD);
  assign bus.ram_we     = (state_q == S_WR);
  assign bus.f_ack      = (state_q == S_ACK) && !gnt_e_q;
  assign bus.e_ack      = (state_q == S_ACK) &&  gnt_e_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq; one DUT per wait-state setting.
module tb_mem_access_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic seen;
  int   ack_cnt;

  always #5 clk = ~clk;

  mem_access_seq_if #(.ADDR_W(8)) if_ws0 ();
  mem_access_seq_if #(.ADDR_W(8)) if_ws1 ();
  mem_access_seq_if #(.ADDR_W(8)) if_ws2 ();
  mem_access_seq_if #(.ADDR_W(8)) if_ws3 ();

  mem_access_seq #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (.clk_i(clk), .rst_i(rst), .bus(if_ws0));
  mem_access_seq #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (.clk_i(clk), .rst_i(rst), .bus(if_ws1));
  mem_access_seq #(.ADDR_W(8), .WAIT_STATES(2)) u_ws2 (.clk_i(clk), .rst_i(rst), .bus(if_ws2));
  mem_access_seq #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (.clk_i(clk), .rst_i(rst), .bus(if_ws3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // strobes must be mutually exclusive in every cycle on every instance
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("onehot_ws0", 32'($countones({if_ws0.mar_ld, if_ws0.mbr_ld_ram, if_ws0.mbr_ld_acc, if_ws0.ram_we}) <= 1), 32'd1);
      chk("onehot_ws1", 32'($countones({if_ws1.mar_ld, if_ws1.mbr_ld_ram, if_ws1.mbr_ld_acc, if_ws1.ram_we}) <= 1), 32'd1);
      chk("onehot_ws2", 32'($countones({if_ws2.mar_ld, if_ws2.mbr_ld_ram, if_ws2.mbr_ld_acc, if_ws2.ram_we}) <= 1), 32'd1);
      chk("onehot_ws3", 32'($countones({if_ws3.mar_ld, if_ws3.mbr_ld_ram, if_ws3.mbr_ld_acc, if_ws3.ram_we}) <= 1), 32'd1);
    end
  end

  initial begin
    rst = 1'b1;
    if_ws0.f_req = 0; if_ws0.f_addr = 0; if_ws0.e_req = 0; if_ws0.e_we = 0; if_ws0.e_addr = 0;
    if_ws1.f_req = 0; if_ws1.f_addr = 0; if_ws1.e_req = 0; if_ws1.e_we = 0; if_ws1.e_addr = 0;
    if_ws2.f_req = 0; if_ws2.f_addr = 0; if_ws2.e_req = 0; if_ws2.e_we = 0; if_ws2.e_addr = 0;
    if_ws3.f_req = 0; if_ws3.f_addr = 0; if_ws3.e_req = 0; if_ws3.e_we = 0; if_ws3.e_addr = 0;
    tick(2);
    rst = 1'b0;
    tick(1);

    // reset state
    chk("rst_busy",    32'(if_ws1.busy),    32'd0);
    chk("rst_mar",     32'(if_ws1.mar_out), 32'h00);
    chk("rst_gnt_e",   32'(if_ws1.gnt_e),   32'd1);
    chk("rst_strobes", 32'({if_ws1.mar_ld, if_ws1.mbr_ld_ram, if_ws1.mbr_ld_acc, if_ws1.ram_we}), 32'd0);
    chk("rst_acks",    32'({if_ws1.f_ack, if_ws1.e_ack}), 32'd0);

    // T2: fetch read, one wait state
    if_ws1.f_req = 1; if_ws1.f_addr = 8'h12;
    chk("t2_c0_idle",   32'(if_ws1.busy),       32'd0);
    tick(1);
    chk("t2_c1_marld",  32'(if_ws1.mar_ld),     32'd1);
    chk("t2_c1_mar",    32'(if_ws1.mar_out),    32'h12);
    chk("t2_c1_gnt_e",  32'(if_ws1.gnt_e),      32'd0);
    tick(1);
    chk("t2_c2_wait",   32'({if_ws1.mar_ld, if_ws1.mbr_ld_ram, if_ws1.busy}), 32'b001);
    tick(1);
    chk("t2_c3_ldram",  32'(if_ws1.mbr_ld_ram), 32'd1);
    tick(1);
    chk("t2_c4_facks",  32'({if_ws1.f_ack, if_ws1.e_ack}), 32'b10);
    if_ws1.f_req = 0;
    tick(1);
    chk("t2_c5_idle",   32'({if_ws1.busy, if_ws1.f_ack}), 32'b00);

    // T3: execute write, two wait states
    if_ws2.e_req = 1; if_ws2.e_we = 1; if_ws2.e_addr = 8'hA5;
    seen = 1'b0;
    tick(1);
    chk("t3_c1_marld",  32'(if_ws2.mar_ld),     32'd1);
    chk("t3_c1_mar",    32'(if_ws2.mar_out),    32'hA5);
    chk("t3_c1_gnt_e",  32'(if_ws2.gnt_e),      32'd1);
    seen = seen | if_ws2.mbr_ld_ram;
    tick(1);
    chk("t3_c2_ldacc",  32'(if_ws2.mbr_ld_acc), 32'd1);
    seen = seen | if_ws2.mbr_ld_ram;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("t3_wr%0d", i), 32'({if_ws2.ram_we, if_ws2.e_ack}), 32'b10);
      seen = seen | if_ws2.mbr_ld_ram;
    end
    tick(1);
    chk("t3_c6_eack",   32'({if_ws2.ram_we, if_ws2.e_ack, if_ws2.f_ack}), 32'b010);
    seen = seen | if_ws2.mbr_ld_ram;
    if_ws2.e_req = 0; if_ws2.e_we = 0;
    tick(1);
    chk("t3_c7_idle",   32'(if_ws2.busy),       32'd0);
    chk("t3_no_ldram",  32'(seen),              32'd0);

    // T4: both held from reset, alternating grants (no wait states)
    if_ws0.f_req = 1; if_ws0.f_addr = 8'h10;
    if_ws0.e_req = 1; if_ws0.e_we = 0; if_ws0.e_addr = 8'h20;
    for (int g = 0; g < 4; g++) begin
      tick(1);
      chk($sformatf("t4_g%0d_gnt_e", g), 32'(if_ws0.gnt_e),   32'(g % 2));
      chk($sformatf("t4_g%0d_mar", g),   32'(if_ws0.mar_out), (g % 2 == 1) ? 32'h20 : 32'h10);
      tick(2);
      chk($sformatf("t4_g%0d_acks", g),  32'({if_ws0.f_ack, if_ws0.e_ack}), (g % 2 == 1) ? 32'b01 : 32'b10);
      if (g == 3) begin
        if_ws0.f_req = 0; if_ws0.e_req = 0;
      end
      tick(1);
      chk($sformatf("t4_g%0d_idle", g),  32'(if_ws0.busy),    32'd0);
    end
    tick(1);
    chk("t4_stays_idle", 32'(if_ws0.busy), 32'd0);

    // T6: zero wait states, fetch read
    if_ws0.f_req = 1; if_ws0.f_addr = 8'h3C;
    tick(1);
    chk("t6_c1_marld",  32'({if_ws0.mar_ld, if_ws0.mbr_ld_ram}), 32'b10);
    tick(1);
    chk("t6_c2_ldram",  32'({if_ws0.mar_ld, if_ws0.mbr_ld_ram}), 32'b01);
    tick(1);
    chk("t6_c3_fack",   32'({if_ws0.f_ack, if_ws0.e_ack}), 32'b10);
    chk("t6_c3_mar",    32'(if_ws0.mar_out), 32'h3C);
    if_ws0.f_req = 0;
    tick(1);
    chk("t6_c4_idle",   32'(if_ws0.busy), 32'd0);

    // T5: request changed and dropped after grant
    if_ws1.e_req = 1; if_ws1.e_we = 0; if_ws1.e_addr = 8'h44;
    ack_cnt = 0;
    tick(1);
    if_ws1.e_req = 0; if_ws1.e_we = 1; if_ws1.e_addr = 8'h99;
    chk("t5_c1_mar",    32'(if_ws1.mar_out), 32'h44);
    for (int c = 2; c <= 7; c++) begin
      tick(1);
      ack_cnt += int'(if_ws1.e_ack);
      if (c == 3) chk("t5_c3_read",   32'({if_ws1.mbr_ld_ram, if_ws1.mbr_ld_acc}), 32'b10);
      if (c == 4) chk("t5_c4_eack",   32'(if_ws1.e_ack), 32'd1);
      if (c == 4) chk("t5_c4_mar",    32'(if_ws1.mar_out), 32'h44);
    end
    chk("t5_one_ack",   32'(ack_cnt), 32'd1);
    chk("t5_idle",      32'(if_ws1.busy), 32'd0);

    // T1: reset in the middle of a write with three wait states
    if_ws3.e_req = 1; if_ws3.e_we = 1; if_ws3.e_addr = 8'h5A;
    tick(2);
    chk("t1_c2_ldacc",  32'(if_ws3.mbr_ld_acc), 32'd1);
    tick(2);
    chk("t1_c4_wr",     32'({if_ws3.ram_we, if_ws3.busy}), 32'b11);
    chk("t1_c4_mar",    32'(if_ws3.mar_out), 32'h5A);
    if_ws3.e_req = 0; if_ws3.e_we = 0;
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_ramwe", 32'(if_ws3.ram_we), 32'd0);
    chk("t1_rst_busy",  32'(if_ws3.busy),   32'd0);
    chk("t1_rst_acks",  32'({if_ws3.f_ack, if_ws3.e_ack}), 32'd0);
    chk("t1_rst_mar",   32'(if_ws3.mar_out), 32'h00);
    chk("t1_rst_gnt_e", 32'(if_ws3.gnt_e),  32'd1);
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("t1_post_idle", 32'({if_ws3.busy, if_ws3.ram_we}), 32'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
